medidor_pulsos: RTL and testbench

Multi-channel, parametrised pulse/period measurement block for the tamagotchi game logic; generalises the single-channel enable-gated cycle counter. Each channel times its `enable` input in clock cycles. Mode 0 measures high time; mode 1 measures rising-to-rising period. Each result has a one-cycle `done` strobe, saturation/overflow reporting and a sticky `valid` flag.

---
 rtl/medidor_pulsos.sv | 125 ++++++++++++
 tb/tb_medidor_pulsos.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_pulsos.sv
// medidor_pulsos: multi-channel pulse/period meter. Each channel counts clock cycles on its
// enable input: high time (i_modo=0) or rising-to-rising period (i_modo=1). Results saturate
// at all-ones and flag overflow.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_enable    per-channel measured signal (already synchronous)
//   i_modo      0 = high time, 1 = full period (all channels)
//   i_clear     synchronous abort/clear of all channels
//   o_periodo   last result per channel, channel i at [i*BIT_PERIODO +: BIT_PERIODO]
//   o_done      one-cycle strobe when a channel's result updates
//   o_overflow  latched result saturated
//   o_valid     sticky: a result has been latched since reset/clear
//   o_busy      channel is counting
module medidor_pulsos #(
  parameter int unsigned N_CANALES   = 4,
  parameter int unsigned BIT_PERIODO = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [N_CANALES-1:0]               i_enable,
  input  logic                               i_modo,
  input  logic                               i_clear,
  output logic [N_CANALES*BIT_PERIODO-1:0]   o_periodo,
  output logic [N_CANALES-1:0]               o_done,
  output logic [N_CANALES-1:0]               o_overflow,
  output logic [N_CANALES-1:0]               o_valid,
  output logic [N_CANALES-1:0]               o_busy
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam logic [BIT_PERIODO-1:0] CntOne = BIT_PERIODO'(1);

  state_e                 r_state [N_CANALES];
  logic [BIT_PERIODO-1:0] r_cnt [N_CANALES];
  logic [BIT_PERIODO-1:0] r_periodo [N_CANALES];
  logic [N_CANALES-1:0]   r_ovf;
  logic [N_CANALES-1:0]   r_enable_q;
  logic                   r_modo_q;
  logic [N_CANALES-1:0]   r_done;
  logic [N_CANALES-1:0]   r_overflow;
  logic [N_CANALES-1:0]   r_valid;

  logic [N_CANALES-1:0]   w_rise;
  logic [N_CANALES-1:0]   w_fall;
  logic                   w_modo_chg;

  assign w_rise     = i_enable & ~r_enable_q;
  assign w_fall     = ~i_enable & r_enable_q;
  assign w_modo_chg = i_modo ^ r_modo_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // All-ones so a level already high at reset release does not look like a rise.
      r_enable_q <= '1;
      r_modo_q   <= 1'b0;
      r_done     <= '0;
      r_overflow <= '0;
      r_valid    <= '0;
      r_ovf      <= '0;
      for (int i = 0; i < N_CANALES; i++) begin
        r_state[i]   <= StIdle;
        r_cnt[i]     <= '0;
        r_periodo[i] <= '0;
      end
    end else begin
      r_enable_q <= i_enable;
      r_modo_q   <= i_modo;
      r_done     <= '0;
      for (int i = 0; i < N_CANALES; i++) begin
        if (i_clear) begin
          r_state[i]    <= StIdle;
          r_periodo[i]  <= '0;
          r_overflow[i] <= 1'b0;
          r_valid[i]    <= 1'b0;
        end else if (w_modo_chg) begin
          // Abort without a result; previous results are kept.
          r_state[i] <= StIdle;
        end else begin
          unique case (r_state[i])
            StIdle: begin
              if (w_rise[i]) begin
                r_cnt[i]   <= CntOne;
                r_ovf[i]   <= 1'b0;
                r_state[i] <= StCount;
              end
            end
            StCount: begin
              if ((!i_modo && w_fall[i]) || (i_modo && w_rise[i])) begin
                r_periodo[i]  <= r_cnt[i];
                r_overflow[i] <= r_ovf[i];
                r_done[i]     <= 1'b1;
                r_valid[i]    <= 1'b1;
                if (i_modo) begin
                  // Next period starts on the same edge: no gap between periods.
                  r_cnt[i] <= CntOne;
                  r_ovf[i] <= 1'b0;
                end else begin
                  r_state[i] <= StIdle;
                end
              end else if (r_cnt[i] == '1) begin
                r_ovf[i] <= 1'b1;
              end else begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
              end
            end
            default: r_state[i] <= StIdle;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < N_CANALES; g++) begin : gen_out
    assign o_periodo[g*BIT_PERIODO +: BIT_PERIODO] = r_periodo[g];
    assign o_busy[g] = (r_state[g] == StCount);
  end

  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_medidor_pulsos.sv
// Directed bench for medidor_pulsos: a 4x16 instance for the main scenarios and a 1x4
// instance for saturation. Inputs change 1 ns after the rising edge, outputs are checked there.
module tb_medidor_pulsos;

  logic        clk;
  logic        rst_n;
  logic [3:0]  enable;
  logic        modo;
  logic        clear;
  logic [63:0] periodo;
  logic [3:0]  done;
  logic [3:0]  overflow;
  logic [3:0]  valid;
  logic [3:0]  busy;

  logic        s_enable;
  logic        s_modo;
  logic        s_clear;
  logic [3:0]  s_periodo;
  logic        s_done;
  logic        s_overflow;
  logic        s_valid;
  logic        s_busy;

  int n_checks;
  int n_pass;

  logic [3:0] exp_done;
  logic [3:0] exp_busy;

  medidor_pulsos #(
    .N_CANALES  (4),
    .BIT_PERIODO(16)
  ) u_dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (enable),
    .i_modo    (modo),
    .i_clear   (clear),
    .o_periodo (periodo),
    .o_done    (done),
    .o_overflow(overflow),
    .o_valid   (valid),
    .o_busy    (busy)
  );

  medidor_pulsos #(
    .N_CANALES  (1),
    .BIT_PERIODO(4)
  ) u_small (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_enable  (s_enable),
    .i_modo    (s_modo),
    .i_clear   (s_clear),
    .o_periodo (s_periodo),
    .o_done    (s_done),
    .o_overflow(s_overflow),
    .o_valid   (s_valid),
    .o_busy    (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    enable   = 4'b0001;
    modo     = 1'b0;
    clear    = 1'b0;
    s_enable = 1'b0;
    s_modo   = 1'b0;
    s_clear  = 1'b0;

    // Reset with ch0 already high.
    tick();
    tick();
    check("rst_periodo", periodo, 64'h0);
    check("rst_done", done, 4'h0);
    check("rst_overflow", overflow, 4'h0);
    check("rst_valid", valid, 4'h0);
    check("rst_busy", busy, 4'h0);
    check("rst_small_periodo", s_periodo, 4'h0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("partial_busy", busy, 4'h0);
    enable = 4'b0000;
    tick();
    check("partial_done", done, 4'h0);
    check("partial_valid", valid, 4'h0);
    tick();

    // Mode 0: ch0 high 7 samples, ch2 high 3 samples, same start.
    for (int k = 0; k < 8; k++) begin
      enable   = {1'b0, (k < 3), 1'b0, (k < 7)};
      tick();
      exp_done = (k == 3) ? 4'b0100 : ((k == 7) ? 4'b0001 : 4'b0000);
      exp_busy = {1'b0, (k < 3), 1'b0, (k < 7)};
      check($sformatf("m0_done_k%0d", k), done, exp_done);
      check($sformatf("m0_busy_k%0d", k), busy, exp_busy);
      if (k == 3) check("m0_periodo2", periodo[32 +: 16], 16'd3);
      if (k == 7) check("m0_periodo0", periodo[0 +: 16], 16'd7);
    end
    check("m0_overflow", overflow, 4'h0);
    check("m0_valid", valid, 4'b0101);

    // Mode 1: ch1 square wave 3 high / 5 low, four periods.
    modo = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) begin
      enable   = {2'b00, ((k % 8) < 3), 1'b0};
      tick();
      exp_done = (k == 8 || k == 16 || k == 24) ? 4'b0010 : 4'b0000;
      check($sformatf("m1_done_k%0d", k), done, exp_done);
      check($sformatf("m1_busy_k%0d", k), busy, 4'b0010);
      if (exp_done != 4'b0000) check($sformatf("m1_periodo1_k%0d", k), periodo[16 +: 16], 16'd8);
    end

    // Mode change mid-measurement: abort without done, results kept.
    modo = 1'b0;
    tick();
    check("mchg_busy", busy, 4'h0);
    check("mchg_done", done, 4'h0);
    check("mchg_periodo1", periodo[16 +: 16], 16'd8);
    check("mchg_valid", valid, 4'b0111);

    // Clear mid-pulse on ch3.
    enable = 4'b1000;
    tick();
    tick();
    check("clr_busy_before", busy, 4'b1000);
    clear = 1'b1;
    tick();
    check("clr_periodo", periodo, 64'h0);
    check("clr_valid", valid, 4'h0);
    check("clr_overflow", overflow, 4'h0);
    check("clr_done", done, 4'h0);
    check("clr_busy", busy, 4'h0);
    clear = 1'b0;
    tick();
    check("clr_no_rise_busy", busy, 4'h0);
    enable = 4'b0000;
    tick();
    check("clr_fall_done", done, 4'h0);

    // ch0 9-cycle pulse, then mode toggle mid-measurement.
    for (int k = 0; k < 10; k++) begin
      enable = {3'b000, (k < 9)};
      tick();
    end
    check("p9_done", done, 4'b0001);
    check("p9_periodo", periodo, 64'd9);
    enable = 4'b0000;
    tick();
    enable = 4'b0001;
    tick();
    tick();
    check("tgl_busy_before", busy, 4'b0001);
    modo = 1'b1;
    tick();
    check("tgl_busy", busy, 4'h0);
    check("tgl_done", done, 4'h0);
    check("tgl_periodo", periodo, 64'd9);
    modo = 1'b0;
    tick();
    enable = 4'b0000;
    tick();
    check("tgl_fall_done", done, 4'h0);
    check("tgl_periodo_kept", periodo, 64'd9);

    // Reset during COUNT with a result latched.
    enable = 4'b0001;
    tick();
    tick();
    check("rst2_busy_before", busy, 4'b0001);
    rst_n = 1'b0;
    tick();
    check("rst2_periodo", periodo, 64'h0);
    check("rst2_valid", valid, 4'h0);
    check("rst2_busy", busy, 4'h0);
    check("rst2_done", done, 4'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check("rst2_busy_after", busy, 4'h0);
    enable = 4'b0000;
    tick();
    check("rst2_fall_done", done, 4'h0);
    check("rst2_fall_valid", valid, 4'h0);

    // 4-bit counter: 20-cycle pulse saturates, then a 6-cycle pulse.
    for (int k = 0; k < 21; k++) begin
      s_enable = (k < 20);
      tick();
    end
    check("sat_done", s_done, 1'b1);
    check("sat_periodo", s_periodo, 4'd15);
    check("sat_overflow", s_overflow, 1'b1);
    check("sat_busy", s_busy, 1'b0);
    for (int k = 0; k < 7; k++) begin
      s_enable = (k < 6);
      tick();
    end
    check("p6_done", s_done, 1'b1);
    check("p6_periodo", s_periodo, 4'd6);
    check("p6_overflow", s_overflow, 1'b0);
    check("p6_valid", s_valid, 1'b1);
    tick();
    check("p6_done_once", s_done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
